// File: rtl/sprite_rom_arbiter_pkg.sv
// sprite_rom_arbiter_pkg: shared FSM states, defaults and the requester address unpack helper
package sprite_rom_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, LO, HI} state_t;
  localparam int NREQ_DEF = 4;
  localparam int ROW_BYTES = 2;
  localparam int ADDR_BUS_MAX = 128;
  function automatic logic [15:0] unpack_addr(input logic [ADDR_BUS_MAX-1:0] bus, input int idx, input int aw);
    return 16'((bus >> (idx * aw)) & ((ADDR_BUS_MAX'(1) << aw) - ADDR_BUS_MAX'(1)));
  endfunction
endpackage

// File: rtl/sprite_rom_arbiter_rr_priority_picker.sv
// rr_priority_picker: first set mask bit at or after ptr, wrapping N-1 -> 0
module rr_priority_picker #(
  parameter int N = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  i_mask,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_winner,
  output logic [IW-1:0] o_index,
  output logic          o_any
);
  // Walk from the farthest candidate back to ptr so the nearest one wins last
  always_comb begin
    o_winner = '0;
    o_index = '0;
    o_any = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (i_mask[(int'(i_ptr) + k) % N]) begin
        o_winner = '0;
        o_winner[(int'(i_ptr) + k) % N] = 1'b1;
        o_index = IW'((int'(i_ptr) + k) % N);
        o_any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/sprite_rom_arbiter.sv
// sprite_rom_arbiter: round-robin sharing of one combinational bitmap ROM,
// fetching a 16-pixel row as a low/high byte pair per grant.
module sprite_rom_arbiter
  import sprite_rom_arbiter_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int AW = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*AW-1:0]     req_addr,
  output logic [NREQ-1:0]        grant,
  output logic [NREQ-1:0]        done,
  output logic [8*ROW_BYTES-1:0] row,
  output logic [AW-1:0]          rom_addr,
  input  logic [7:0]             rom_bits,
  output logic                   busy
);
  localparam int IW = $clog2(NREQ);
  state_t r_state, w_next;
  logic [IW-1:0] r_rr_ptr, r_win, w_idx;
  logic [NREQ-1:0] r_done, w_mask, w_winner;
  logic w_any, w_take;
  logic [7:0] r_lo;
  logic [8*ROW_BYTES-1:0] r_row;
  logic [AW-1:0] r_rom_addr, w_sel_addr, w_base;
  // A requester still seeing its done strobe sits out this arbitration
  assign w_mask = req & ~r_done;
  rr_priority_picker #(.N(NREQ), .IW(IW)) u_pick (
    .i_mask(w_mask),
    .i_ptr(r_rr_ptr),
    .o_winner(w_winner),
    .o_index(w_idx),
    .o_any(w_any)
  );
  assign w_sel_addr = AW'(unpack_addr(ADDR_BUS_MAX'(req_addr), int'(w_idx), AW));
  assign w_base = w_sel_addr & ~AW'(1);
  assign w_take = (r_state == IDLE) && w_any;
  assign grant = (reset && r_state == IDLE) ? w_winner : '0;
  assign done = r_done;
  assign row = r_row;
  assign rom_addr = r_rom_addr;
  assign busy = r_state != IDLE;
  always_comb begin
    w_next = r_state;
    w_next = (r_state == IDLE) ? (w_any ? LO : IDLE) : (r_state == LO) ? HI : IDLE;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_rr_ptr <= '0;
      r_win <= '0;
      r_done <= '0;
      r_lo <= '0;
      r_row <= '0;
      r_rom_addr <= '0;
    end else begin
      r_state <= w_next;
      r_done <= (r_state == HI) ? NREQ'(1) << r_win : '0;
      if (w_take) begin
        r_win <= w_idx;
        r_rom_addr <= w_base;
      end
      if (r_state == LO) begin
        r_lo <= rom_bits;
        r_rom_addr <= r_rom_addr | AW'(1);
      end
      if (r_state == HI) begin
        r_row <= {rom_bits, r_lo};
        r_rr_ptr <= (r_win == IW'(NREQ - 1)) ? '0 : r_win + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// tb_sprite_rom_arbiter: directed scenarios plus randomized traffic against a transaction-level model
module tb_sprite_rom_arbiter;
  logic clk = 1'b0;
  logic reset;
  logic [3:0] req, grant, done;
  logic [31:0] req_addr;
  logic [15:0] row;
  logic [7:0] rom_addr, rom_bits;
  logic busy;
  logic [7:0] rom [256];
  int n_asrt = 0, n_fail = 0;
  int g, gw, ptr, w;
  logic [7:0] gbase, exp_ra, a;
  logic [15:0] exp_row, pend_row;
  logic [3:0] exp_done, exp_grant, elig;
  logic exp_busy;

  sprite_rom_arbiter #(.NREQ(4), .AW(8)) dut (
    .clk(clk), .reset(reset), .req(req), .req_addr(req_addr), .grant(grant), .done(done),
    .row(row), .rom_addr(rom_addr), .rom_bits(rom_bits), .busy(busy)
  );
  assign rom_bits = rom[rom_addr];
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
    rom[8'h12] = 8'hAB; rom[8'h13] = 8'hCD;
    rom[8'h40] = 8'h11; rom[8'h41] = 8'h22;
    rom[8'h50] = 8'h33; rom[8'h51] = 8'h44;
    reset = 1'b0; req = '0; req_addr = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_grant", grant, 0); chk("rst_done", done, 0); chk("rst_row", row, 0);
    chk("rst_rom_addr", rom_addr, 0); chk("rst_busy", busy, 0);
    @(negedge clk); reset = 1'b1;
    // single request, even address
    @(negedge clk); req = 4'b0010; req_addr[15:8] = 8'h12; #1;
    chk("single_grant", grant, 4'b0010); chk("single_busy0", busy, 0);
    @(negedge clk); #1; chk("single_ra_lo", rom_addr, 8'h12); chk("single_busy1", busy, 1); chk("single_grant_off", grant, 0);
    @(negedge clk); #1; chk("single_ra_hi", rom_addr, 8'h13);
    @(negedge clk); req = '0; #1;
    chk("single_done", done, 4'b0010); chk("single_row", row, 16'hCDAB); chk("single_busy_end", busy, 0);
    @(negedge clk); #1; chk("single_done_off", done, 0); chk("single_row_hold", row, 16'hCDAB); chk("idle_ra_hold", rom_addr, 8'h13);
    // odd address, req held through done, address changed after grant
    @(negedge clk); req = 4'b0100; req_addr[23:16] = 8'h13; #1; chk("odd_grant", grant, 4'b0100);
    @(negedge clk); req_addr[23:16] = 8'h40; #1; chk("odd_ra_lo", rom_addr, 8'h12);
    @(negedge clk); #1; chk("odd_ra_hi", rom_addr, 8'h13);
    @(negedge clk); #1;
    chk("odd_done", done, 4'b0100); chk("odd_row", row, 16'hCDAB); chk("held_no_regrant", grant, 0);
    @(negedge clk); #1; chk("held_wrap_grant", grant, 4'b0100);
    repeat (2) @(negedge clk);
    @(negedge clk); req = '0; #1; chk("held_done", done, 4'b0100); chk("held_row", row, 16'h2211);
    // withdrawal mid-burst
    @(negedge clk); req = 4'b0001; req_addr[7:0] = 8'h50; #1; chk("wd_grant", grant, 4'b0001);
    @(negedge clk); req = '0; #1; chk("wd_busy", busy, 1);
    @(negedge clk); #1;
    @(negedge clk); #1; chk("wd_done", done, 4'b0001); chk("wd_row", row, 16'h4433);
    @(negedge clk); #1; chk("wd_no_grant", grant, 0); chk("wd_done_off", done, 0);
    // reset during a burst, then rr_ptr restarts at 0
    @(negedge clk); req = 4'b0100; #1; chk("mr_grant", grant, 4'b0100);
    @(negedge clk); #1;
    @(negedge clk); reset = 1'b0; req = 4'b1001; #1;
    chk("mr_grant0", grant, 0); chk("mr_done0", done, 0); chk("mr_row0", row, 0);
    chk("mr_ra0", rom_addr, 0); chk("mr_busy0", busy, 0);
    @(negedge clk); reset = 1'b1; #1; chk("mr_ptr0_grant", grant, 4'b0001);
    @(negedge clk); #1; @(negedge clk); #1; @(negedge clk); #1; chk("mr_no_stale_done", done, 4'b0001);
    // all four requesting continuously from reset
    @(negedge clk); reset = 1'b0; req = '0; #1;
    @(negedge clk); reset = 1'b1; req = 4'b1111; req_addr = 32'h26242220; #1;
    for (int k = 0; k < 8; k++) begin
      chk("rr_grant", grant, 32'(1) << (k % 4));
      if (k > 0) begin
        a = 8'(8'h20 + 2 * ((k - 1) % 4));
        chk("rr_done", done, 32'(1) << ((k - 1) % 4));
        chk("rr_row", row, {rom[a | 8'h01], rom[a]});
      end
      @(negedge clk); #1; chk("rr_gap1", grant, 0);
      @(negedge clk); #1; chk("rr_gap2", grant, 0);
      @(negedge clk); #1;
    end
    // randomized traffic against the transaction model
    @(negedge clk); reset = 1'b0; req = '0; #1;
    @(negedge clk); reset = 1'b1;
    g = -100; gw = 0; ptr = 0; gbase = '0; exp_ra = '0; exp_row = '0; pend_row = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      req = 4'($urandom) & 4'($urandom | $urandom);
      req_addr = $urandom;
      #1;
      exp_done = (cyc == g + 3) ? 4'(1 << gw) : 4'b0;
      if (cyc == g + 3) exp_row = pend_row;
      if (cyc == g + 1) exp_ra = gbase;
      if (cyc == g + 2) exp_ra = gbase | 8'h01;
      exp_busy = (cyc > g) && (cyc < g + 3);
      exp_grant = '0;
      if (cyc >= g + 3) begin
        elig = req & ~exp_done;
        w = -1;
        for (int k = 0; k < 4; k++) if (w < 0 && elig[(ptr + k) % 4]) w = (ptr + k) % 4;
        if (w >= 0) begin
          exp_grant = 4'(1 << w);
          g = cyc; gw = w;
          gbase = 8'(req_addr >> (8 * w)) & 8'hFE;
          pend_row = {rom[gbase | 8'h01], rom[gbase]};
          ptr = (w + 1) % 4;
        end
      end
      chk("rnd_grant", grant, exp_grant);
      chk("rnd_done", done, exp_done);
      chk("rnd_row", row, exp_row);
      chk("rnd_rom_addr", rom_addr, exp_ra);
      chk("rnd_busy", busy, exp_busy);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule

// File: doc/sprite_rom_arbiter.md
# sprite_rom_arbiter

Shares one combinational sprite bitmap ROM (8-bit address, 8-bit data, 16-pixel rows stored as low/high byte pairs) between up to NREQ sprite renderers. Each renderer requests one 16-bit bitmap row per scanline. The arbiter grants requesters round-robin, performs the two-byte fetch, and returns the assembled row with a one-cycle done strobe. It sits between the tank/sprite controllers and the bitmap ROM, so several tanks can be drawn from one ROM instance.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- AW, 8, ROM address width

Ports:
- clk  in  1  pixel clock; single clock domain
- reset  in  1  asynchronous, active-low (asserted at 0)
- req  in  NREQ  per-requester row request, level, held until done
- req_addr  in  NREQ*AW  per-requester row base address, packed requester i at [i*AW +: AW]; bit 0 ignored
- grant  out  NREQ  one-hot, high for the cycle a burst is accepted
- done  out  NREQ  one-hot, one-cycle strobe: row valid for that requester
- row  out  16  fetched row, low byte = even address; valid when any done bit is high, held until the next done
- rom_addr  out  AW  registered address to the ROM
- rom_bits  in  8  ROM data, combinational from rom_addr
- busy  out  1  high while a burst is in flight (LO or HI state)

## Operation
- FSM states: IDLE, LO, HI.
- IDLE:
  - Evaluate the eligible mask = req & ~done.
  - If the mask is non-zero, pick the winner by round-robin search starting at rr_ptr, wrapping at NREQ-1 → 0.
  - On a winner: pulse grant[w]; latch base = {req_addr[w][AW-1:1], 0}; set rom_addr ← base; go to LO.
- LO: latch lo ← rom_bits; set rom_addr ← base|1; go to HI.
- HI:
  - Set row ← {rom_bits, lo}.
  - Set done[w] ← 1 (registered, so visible in the next cycle, which is IDLE).
  - Set rr_ptr ← (w+1) mod NREQ.
  - Go to IDLE.
- Masking on done: a requester whose done is high in IDLE cannot win that cycle. This prevents a double grant while the requester is still dropping req.
- Request withdrawal: if req[w] falls mid-burst, the burst still completes and done[w] still pulses.
- Address stability: req_addr is sampled only at grant. Changes after grant do not affect the current burst.
- No request: in IDLE with the mask zero, the FSM stays idle; rom_addr and row hold their values.
- Reset values: state IDLE, rr_ptr 0, grant 0, done 0, row 0, rom_addr 0, busy 0, lo 0.
- Reset mid-burst: the burst is abandoned and no done is issued. The requester must re-request after reset deasserts.

## Timing
- Latency: req high in IDLE at cycle T → grant at T; rom_addr = base at T+1; base|1 at T+2; done and row visible at T+3.
- Throughput: one burst per 3 cycles. Back-to-back grants occur at T, T+3, T+6, …
- With NREQ=4 all busy, one row per requester takes 12 cycles. This fits easily in the horizontal blank; the controllers issue req on hsync.
- grant and done are never high in the same cycle for the same requester. grant to requester j may coincide with done to requester i≠j.
- Requester rule: drop req in the cycle done is observed, or keep it high to request the next row. In the second case the row is re-requested at its next round-robin turn, not immediately.

## Structure
- Shared package holds:
  - state enum {IDLE, LO, HI}
  - NREQ default
  - ROW_BYTES = 2
  - the helper function for packing/unpacking requester addresses
- Sub-module rr_priority_picker (combinational):
  - inputs: mask[NREQ], ptr
  - outputs: one-hot winner, index, any
  - reused later by other shared-resource arbiters
- The arbiter core (FSM, address/row registers, rr_ptr) stays in sprite_rom_arbiter.

## Test plan
- Single request, ROM pair {0x12→0xAB, 0x13→0xCD}: req[1]=1, req_addr[1]=0x12 → grant[1] at T, rom_addr 0x12/0x13 at T+1/T+2, done[1] at T+3, row=0xCDAB.
- Odd address: req_addr=0x13 → fetches 0x12/0x13, same row as above.
- All 4 requesting continuously from reset → grant order 0,1,2,3,0,1…, one grant every 3 cycles, each done matches its own address.
- Requester 2 keeps req high through done → no grant to 2 in the done cycle; the next grant goes to 3 if requesting, else wraps.
- req[0] dropped at T+1 → done[0] still pulses at T+3; no further grant to 0.
- reset driven low at T+2 of a burst → grant/done/row/rom_addr/busy all 0 immediately; after release, a new req is granted with rr_ptr=0 priority.
